outr_serial_tx: RTL and testbench
=================================

// Module: outr_serial_tx
// PURPOSE
//  Output-device stage downstream of the OUTR register. Consumes the 8-bit OUTR
//  value and its load strobe (CON[4]), and serialises it onto a single TXD line
//  as an async frame: start bit, LSB-first data, stop bit.
//  Drives the FGO flag back to the controller: 1 = device ready for a new character.
// PARAMETERS
//  CLKS_PER_BIT  4   CLK cycles per serial bit; legal range 2..65535
//  DATA_W        8   data bits per frame; equals OUTR width
//  STOP_BITS     1   stop bits per frame; legal values 1 or 2
// PORTS
//  CLK       in   1       system clock, rising edge
//  CLR       in   1       synchronous, active-high reset
//  OUT_DATA  in   DATA_W  OUTR contents (REG_OUT)
//  OUT_LD    in   1       OUTR load strobe (CON[4]); sampled on the edge after load
//  FGO       out  1       output flag: 1 = idle and ready, 0 = frame in progress
//  TXD       out  1       serial line; idles high
//  OVR       out  1       sticky overrun: OUT_LD seen while FGO=0
// BEHAVIOUR
//  - One clock (CLK). Reset is synchronous and active-high (CLR): at a rising CLK
//    edge with CLR=1 -> state IDLE, FGO=1, TXD=1, OVR=0, counters=0, shifter=0.
//    CLR has priority over every other event, including mid-frame.
//  - FSM states: IDLE, START, DATA, STOP.
//    IDLE: TXD=1, FGO=1. On an edge with OUT_LD=1: capture OUT_DATA into the
//      shifter, clear FGO to 0, go to START. TXD is 0 from the next cycle on.
//    START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
//    DATA: TXD=shifter[0] for CLKS_PER_BIT cycles per bit; shift right after
//      each bit. After bit DATA_W-1 go to STOP.
//    STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final stop cycle:
//      go to IDLE and set FGO=1 at the same edge.
//  - Baud counter: 0..CLKS_PER_BIT-1. Wraps to 0 at each bit boundary. Reset to 0
//    on every state change.
//  - Frame length: (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles from the first TXD=0
//    cycle to FGO=1.
//  - Back-to-back: OUT_LD on the first cycle FGO=1 is accepted. The next start bit
//    follows the stop bit directly, with no extra idle cycle.
//  - OUT_LD while FGO=0: data is ignored and the frame in flight is unaffected.
//    OVR is set to 1 and stays 1 until CLR.
//  - OUT_LD while CLR=1: ignored; reset wins.
//  - OUT_DATA is sampled only at the accepting edge. Later changes to OUTR do not
//    alter the frame.
//  - All outputs are registered. There are no combinational paths from input to output.
// TESTING (CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
//  1 Reset: CLR high for 2 cycles, with OUT_LD=1 and OUT_DATA=8'hFF ->
//    FGO=1, TXD=1, OVR=0; no frame starts.
//  2 Single frame: OUT_DATA=8'hA5, OUT_LD pulse -> TXD is 0 for 4 cycles, then
//    1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. FGO=0 for exactly
//    40 cycles, then returns to 1. OVR stays 0.
//  3 Back-to-back: send 8'h00, then 8'hFF on the first FGO=1 cycle ->
//    two contiguous 40-cycle frames with no idle gap between them.
//  4 Overrun: send 8'h3C, then pulse OUT_LD with 8'hC3 at cycle 10 ->
//    TXD carries 3C only, OVR=1 from cycle 11 onward, and OVR stays 1 after the
//    frame ends.
//  5 Mid-frame reset: CLR during DATA bit 3 of 8'h55 -> next cycle TXD=1, FGO=1,
//    OVR=0. A new OUT_LD then produces a full, correct frame.
//  6 STOP_BITS=2, CLKS_PER_BIT=2: send 8'h81 -> 22-cycle frame, stop level held
//    for 4 cycles.

Source files
------------

// File: rtl/outr_serial_tx.sv
// Output-device stage behind OUTR: serialises each loaded character onto TXD as
// an async frame (start bit, LSB-first data, stop bits) and reports readiness on FGO.
module outr_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [DATA_W-1:0] OUT_DATA,
    input  logic              OUT_LD,
    output logic              FGO,
    output logic              TXD,
    output logic              OVR
);

    localparam int unsigned BAUD_W = 16;
    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                fgo_q, fgo_d;
    logic                txd_q, txd_d;
    logic                ovr_q, ovr_d;
    logic                bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves one unassigned (no latches).
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        fgo_d     = fgo_q;
        txd_d     = txd_q;
        ovr_d     = ovr_q;

        // A load while busy is dropped; only the sticky flag records it.
        if (OUT_LD && !fgo_q) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                fgo_d = 1'b1;
                if (OUT_LD) begin
                    shift_d = OUT_DATA;
                    fgo_d   = 1'b0;
                    txd_d   = 1'b0;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        txd_d     = 1'b1;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        txd_d     = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        fgo_d     = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                baud_d    = '0;
                bit_cnt_d = '0;
                fgo_d     = 1'b1;
                txd_d     = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    // NOTE: the shifter is an ordinary register, so it is cleared with the rest of the state.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            fgo_q     <= 1'b1;
            txd_q     <= 1'b1;
            ovr_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            fgo_q     <= fgo_d;
            txd_q     <= txd_d;
            ovr_q     <= ovr_d;
        end
    end

    assign FGO = fgo_q;
    assign TXD = txd_q;
    assign OVR = ovr_q;

endmodule

// File: tb/tb_outr_serial_tx.sv
// Bench for outr_serial_tx: two instances (4 clk/bit 1 stop, 2 clk/bit 2 stops)
// checked cycle by cycle against a queue-of-line-levels reference, plus directed frames.
module tb_outr_serial_tx;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic [N-1:0]   clr;
    logic [N-1:0]   ld;
    logic [7:0]     dat [N];
    logic [N-1:0]   fgo;
    logic [N-1:0]   txd;
    logic [N-1:0]   ovr;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_en   = 1'b0;
    logic samp [0:63];
    int   low;

    always #5 clk = ~clk;

    outr_serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .STOP_BITS(1)) dut_a (
        .CLK(clk), .CLR(clr[0]), .OUT_DATA(dat[0]), .OUT_LD(ld[0]),
        .FGO(fgo[0]), .TXD(txd[0]), .OVR(ovr[0])
    );

    outr_serial_tx #(.CLKS_PER_BIT(2), .DATA_W(8), .STOP_BITS(2)) dut_b (
        .CLK(clk), .CLR(clr[1]), .OUT_DATA(dat[1]), .OUT_LD(ld[1]),
        .FGO(fgo[1]), .TXD(txd[1]), .OVR(ovr[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: the line levels still owed for the frame in flight; empty queue = ready.
    for (genvar g = 0; g < N; g++) begin : g_model
        localparam int CPB = (g == 0) ? 4 : 2;
        localparam int STP = (g == 0) ? 1 : 2;
        bit q [$];
        bit m_ovr = 1'b0;
        bit e_txd = 1'b1;
        bit e_fgo = 1'b1;
        bit was_idle;

        always @(posedge clk) begin
            was_idle = (q.size() == 0);
            if (clr[g] === 1'b1) begin
                q.delete();
                m_ovr = 1'b0;
            end else begin
                if (!was_idle) void'(q.pop_front());
                if (ld[g] === 1'b1) begin
                    if (was_idle) begin
                        for (int i = 0; i < CPB; i++) q.push_back(1'b0);
                        for (int b = 0; b < 8; b++)
                            for (int i = 0; i < CPB; i++) q.push_back(dat[g][b]);
                        for (int i = 0; i < STP * CPB; i++) q.push_back(1'b1);
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
            end
            e_txd = (q.size() == 0) ? 1'b1 : q[0];
            e_fgo = (q.size() == 0);
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check($sformatf("txd%0d", g), 32'(txd[g]), 32'(e_txd));
                check($sformatf("fgo%0d", g), 32'(fgo[g]), 32'(e_fgo));
                check($sformatf("ovr%0d", g), 32'(ovr[g]), 32'(m_ovr));
            end
        end
    end

    // Line level at offset idx from the first start-bit cycle.
    function automatic logic exp_level(input logic [7:0] d, input int cpb, input int idx);
        if (idx < cpb) return 1'b0;
        if (idx < 9 * cpb) return d[idx / cpb - 1];
        return 1'b1;
    endfunction

    task automatic send(input int k, input logic [7:0] d);
        dat[k] = d;
        ld[k]  = 1'b1;
        @(negedge clk);
        ld[k]  = 1'b0;
    endtask

    task automatic collect(input int k, output int n_low);
        n_low = 0;
        while (fgo[k] === 1'b0 && n_low < 200) begin
            if (n_low < 64) samp[n_low] = txd[k];
            n_low++;
            @(negedge clk);
        end
        if (n_low >= 200) check("frame_timeout", 32'(n_low), 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input int cpb,
                               input int stp, input int n_low);
        check({tag, "_len"}, 32'(n_low), 32'((1 + 8 + stp) * cpb));
        for (int i = 0; i < n_low && i < 64; i++)
            check($sformatf("%s_bit%0d", tag, i), 32'(samp[i]), 32'(exp_level(d, cpb, i)));
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            clr[k] = 1'b1;
            ld[k]  = 1'b1;
            dat[k] = 8'hFF;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst_fgo%0d", k), 32'(fgo[k]), 32'd1);
            check($sformatf("rst_txd%0d", k), 32'(txd[k]), 32'd1);
            check($sformatf("rst_ovr%0d", k), 32'(ovr[k]), 32'd0);
            clr[k] = 1'b0;
            ld[k]  = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("rst_no_frame", 32'(fgo[0]), 32'd1);

        // Single frame
        send(0, 8'hA5);
        collect(0, low);
        check_frame("a5", 8'hA5, 4, 1, low);
        check("a5_ovr", 32'(ovr[0]), 32'd0);

        // Back-to-back: second load on the first ready cycle
        repeat (3) @(negedge clk);
        send(0, 8'h00);
        collect(0, low);
        check_frame("b2b_00", 8'h00, 4, 1, low);
        send(0, 8'hFF);
        collect(0, low);
        check_frame("b2b_ff", 8'hFF, 4, 1, low);

        // Overrun at frame cycle 10
        repeat (3) @(negedge clk);
        send(0, 8'h3C);
        repeat (9) @(negedge clk);
        check("ovr_before", 32'(ovr[0]), 32'd0);
        send(0, 8'hC3);
        check("ovr_set", 32'(ovr[0]), 32'd1);
        collect(0, low);
        check("ovr_rest_len", 32'(low), 32'd30);
        for (int i = 0; i < low && i < 30; i++)
            check($sformatf("ovr_bit%0d", i + 10), 32'(samp[i]), 32'(exp_level(8'h3C, 4, i + 10)));
        repeat (4) @(negedge clk);
        check("ovr_sticky", 32'(ovr[0]), 32'd1);

        // Mid-frame reset during data bit 3
        send(0, 8'h55);
        repeat (3) @(negedge clk);
        send(0, 8'hAA);
        repeat (13) @(negedge clk);
        check("mid_bit3", 32'(txd[0]), 32'd0);
        check("mid_ovr_pre", 32'(ovr[0]), 32'd1);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check("mid_txd", 32'(txd[0]), 32'd1);
        check("mid_fgo", 32'(fgo[0]), 32'd1);
        check("mid_ovr", 32'(ovr[0]), 32'd0);
        send(0, 8'h55);
        collect(0, low);
        check_frame("mid_55", 8'h55, 4, 1, low);

        // Two stop bits, two clocks per bit
        send(1, 8'h81);
        collect(1, low);
        check_frame("s2_81", 8'h81, 2, 2, low);

        // Randomised traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                clr[k] = ($urandom_range(0, 299) == 0);
                ld[k]  = ($urandom_range(0, 5) == 0);
                dat[k] = 8'($urandom);
            end
            @(negedge clk);
        end
        ld = '0;
        clr = '0;
        repeat (60) @(negedge clk);
        check("end_idle0", 32'(fgo[0]), 32'd1);
        check("end_idle1", 32'(fgo[1]), 32'd1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
